// File: rtl/tick_timer_pkg.sv
// Shared project constants: clock-divider settings and the countdown timer
// state encoding.
package tick_timer_pkg;

    // Divider feeding TICK: one strobe every DIV_RATIO_DEFAULT clocks.
    localparam int unsigned DIV_RATIO_DEFAULT = 4;
    localparam int unsigned DIV_CNT_WIDTH     = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_EXPIRE = 2'd2;

    function automatic logic state_is_busy(input logic [1:0] st);
        return st == ST_RUN;
    endfunction

    function automatic logic state_is_expired(input logic [1:0] st);
        return st == ST_EXPIRE;
    endfunction

endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle of the tick timer; master drives commands, slave
// (the timer) drives status.
interface tick_timer_if #(
    parameter int unsigned WIDTH = 10
);
    logic             TICK;
    logic             START;
    logic [WIDTH-1:0] LOAD_VALUE;
    logic             CANCEL;
    logic             HOLD;
    logic             BUSY;
    logic             EXPIRED;
    logic [WIDTH-1:0] REMAINING;

    modport master (
        output TICK, START, LOAD_VALUE, CANCEL, HOLD,
        input  BUSY, EXPIRED, REMAINING
    );

    modport slave (
        input  TICK, START, LOAD_VALUE, CANCEL, HOLD,
        output BUSY, EXPIRED, REMAINING
    );
endinterface

// File: rtl/tick_timer.sv
// Countdown timer driven by an external single-cycle tick strobe; all
// status outputs come straight from flops.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic        CLK,
    input  logic        RST,
    tick_timer_if.slave bus
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;

    // Priority: CANCEL > START > HOLD > TICK; reset is applied in the flops.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (bus.CANCEL) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (bus.START) begin
            remaining_d = bus.LOAD_VALUE;
            state_d     = (bus.LOAD_VALUE == '0) ? ST_EXPIRE : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.HOLD && bus.TICK) begin
                        // Saturate at zero; a count of 0 or 1 ends the run.
                        if (remaining_q <= WIDTH'(1)) begin
                            remaining_d = '0;
                            state_d     = ST_EXPIRE;
                        end else begin
                            remaining_d = remaining_q - WIDTH'(1);
                        end
                    end
                end
                ST_EXPIRE: state_d = ST_IDLE;
                ST_IDLE:   state_d = ST_IDLE;
                default: begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end
            endcase
        end
        busy_d    = state_is_busy(state_d);
        expired_d = state_is_expired(state_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.EXPIRED   = expired_q;
    assign bus.REMAINING = remaining_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: hand-computed BUSY/EXPIRED/REMAINING after
// every clock edge.
module tb_tick_timer;

    localparam int unsigned WIDTH = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    tick_timer_if #(.WIDTH(WIDTH)) bus ();

    tick_timer #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int unsigned busy,
                              input int unsigned expired, input int unsigned rem);
        check_eq({tag, ".busy"}, int'(bus.BUSY), busy);
        check_eq({tag, ".expired"}, int'(bus.EXPIRED), expired);
        check_eq({tag, ".remaining"}, int'(bus.REMAINING), rem);
        $display("txn %-14s busy=%0d expired=%0d remaining=%0d", tag, bus.BUSY, bus.EXPIRED, bus.REMAINING);
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.TICK       = 1'b0;
        bus.START      = 1'b0;
        bus.CANCEL     = 1'b0;
        bus.HOLD       = 1'b0;
        bus.LOAD_VALUE = '0;
    endtask

    task automatic do_start(input int unsigned val);
        bus.START      = 1'b1;
        bus.LOAD_VALUE = WIDTH'(val);
        step();
        bus.START      = 1'b0;
    endtask

    task automatic do_tick();
        bus.TICK = 1'b1;
        step();
        bus.TICK = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();

        // Reset overrides a simultaneous START.
        rst = 1'b1;
        bus.START = 1'b1;
        bus.LOAD_VALUE = WIDTH'(7);
        step();
        step();
        expect_out("reset", 0, 0, 0);
        rst = 1'b0;
        clear_inputs();
        step();
        expect_out("post_reset", 0, 0, 0);

        // Load 3, tick every 4th cycle.
        do_start(3);
        expect_out("l3_start", 1, 0, 3);
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 3; i++) begin
                step();
                expect_out("l3_wait", 1, 0, 3 - t);
            end
            do_tick();
            if (t < 2) expect_out("l3_tick", 1, 0, 2 - t);
        end
        expect_out("l3_expire", 0, 1, 0);
        do_tick();
        expect_out("l3_idle", 0, 0, 0);

        // Load 0 expires immediately, never busy.
        do_start(0);
        expect_out("l0_expire", 0, 1, 0);
        step();
        expect_out("l0_idle", 0, 0, 0);

        // Load 5, CANCEL with START after 2 ticks.
        do_start(5);
        expect_out("l5_start", 1, 0, 5);
        do_tick();
        expect_out("l5_tick1", 1, 0, 4);
        do_tick();
        expect_out("l5_tick2", 1, 0, 3);
        bus.CANCEL = 1'b1;
        bus.START = 1'b1;
        bus.LOAD_VALUE = WIDTH'(7);
        bus.TICK = 1'b1;
        step();
        clear_inputs();
        expect_out("l5_cancel", 0, 0, 0);
        step();
        expect_out("l5_after", 0, 0, 0);

        // Load 4, HOLD across 3 ticks after the first.
        do_start(4);
        expect_out("l4_start", 1, 0, 4);
        do_tick();
        expect_out("l4_tick1", 1, 0, 3);
        bus.HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_tick();
            expect_out("l4_hold_tick", 1, 0, 3);
            step();
            expect_out("l4_hold_gap", 1, 0, 3);
        end
        bus.HOLD = 1'b0;
        step();
        expect_out("l4_unhold", 1, 0, 3);
        do_tick();
        expect_out("l4_tick2", 1, 0, 2);
        do_tick();
        expect_out("l4_tick3", 1, 0, 1);
        do_tick();
        expect_out("l4_expire", 0, 1, 0);
        step();
        expect_out("l4_idle", 0, 0, 0);

        // Load 6, restart with 2 at REMAINING=4 while a tick arrives.
        do_start(6);
        expect_out("l6_start", 1, 0, 6);
        do_tick();
        do_tick();
        expect_out("l6_at4", 1, 0, 4);
        bus.TICK = 1'b1;
        do_start(2);
        bus.TICK = 1'b0;
        expect_out("l6_restart", 1, 0, 2);
        do_tick();
        expect_out("l6_tick", 1, 0, 1);
        do_tick();
        expect_out("l6_expire", 0, 1, 0);

        // START during EXPIRE is accepted.
        do_start(2);
        expect_out("exp_restart", 1, 0, 2);
        do_tick();
        do_tick();
        expect_out("exp_expire", 0, 1, 0);
        bus.START = 1'b1;
        bus.LOAD_VALUE = WIDTH'(9);
        step();
        bus.START = 1'b0;
        expect_out("start_in_exp", 1, 0, 9);
        bus.CANCEL = 1'b1;
        step();
        bus.CANCEL = 1'b0;
        expect_out("cancel_run", 0, 0, 0);

        // Reset at REMAINING=1 with a coincident tick.
        do_start(2);
        do_tick();
        expect_out("rst_at1", 1, 0, 1);
        rst = 1'b1;
        bus.TICK = 1'b1;
        step();
        rst = 1'b0;
        bus.TICK = 1'b0;
        expect_out("rst_abort", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            expect_out("rst_quiet", 0, 0, 0);
        end

        // First edge after reset behaves as IDLE; load 1 expires on one tick.
        do_start(1);
        expect_out("l1_start", 1, 0, 1);
        do_tick();
        expect_out("l1_expire", 0, 1, 0);

        // Full-scale load.
        do_start(1023);
        expect_out("lmax_start", 1, 0, 1023);
        do_tick();
        expect_out("lmax_tick", 1, 0, 1022);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter: WIDTH, default 10, bit width of the load value and the remaining count.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: TICK  input  1  single-cycle strobe from the clock divider; one decrement per asserted cycle.
REQ-005 Port: START  input  1  load LOAD_VALUE and begin countdown.
REQ-006 Port: LOAD_VALUE  input  WIDTH  countdown length in ticks, sampled only on an accepted START.
REQ-007 Port: CANCEL  input  1  abort countdown, return to idle without expiry.
REQ-008 Port: HOLD  input  1  freeze countdown while high; TICK is ignored.
REQ-009 Port: BUSY  output  1  high while the countdown is running.
REQ-010 Port: EXPIRED  output  1  single-cycle pulse when the countdown reaches zero.
REQ-011 Port: REMAINING  output  WIDTH  current remaining tick count.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and EXPIRE.
REQ-013 All outputs SHALL be registered; BUSY=1 exactly in RUN, EXPIRED=1 exactly in EXPIRE.
REQ-014 Per-edge priority order SHALL be: RST > CANCEL > START > HOLD > TICK.
REQ-015 IDLE with START and LOAD_VALUE!=0: next state RUN, REMAINING<=LOAD_VALUE; BUSY rises one cycle after the START edge.
REQ-016 IDLE with START and LOAD_VALUE==0: next state EXPIRE, REMAINING<=0; RUN is not entered.
REQ-017 IDLE and EXPIRE SHALL ignore TICK and HOLD; REMAINING holds its value.
REQ-018 RUN with TICK, HOLD=0, REMAINING>1: REMAINING decrements by 1 and the FSM stays in RUN.
REQ-019 RUN with TICK, HOLD=0, REMAINING==1: REMAINING<=0 and next state EXPIRE; EXPIRED is high on the following cycle.
REQ-020 EXPIRE SHALL last exactly one cycle, then go to IDLE; a START in EXPIRE SHALL be accepted as in IDLE.
REQ-021 RUN with START: reload from LOAD_VALUE (restart), the same-cycle TICK is discarded, and EXPIRE is entered if LOAD_VALUE==0.
REQ-022 CANCEL in any state: next state IDLE, REMAINING<=0, no EXPIRED pulse, and START in the same cycle is ignored.
REQ-023 HOLD=1 in RUN: REMAINING and state are frozen; counting resumes with the first TICK after HOLD falls.
REQ-024 Decrement SHALL never wrap: REMAINING never goes below 0.
REQ-025 Expiry-to-EXPIRED latency SHALL be 1 cycle after the final TICK edge; total ticks consumed SHALL equal LOAD_VALUE.

Reset
REQ-026 On RST=1 at a rising edge: state IDLE, BUSY=0, EXPIRED=0, REMAINING=0, overriding all other inputs.
REQ-027 RST asserted mid-countdown SHALL abort without an EXPIRED pulse; the first edge after RST falls behaves as IDLE.

Structure
REQ-028 The state encoding constants (IDLE, RUN, EXPIRE) SHALL reside in the shared project package, next to the divider constants.
REQ-029 No sub-module SHALL be used; TICK is already a single-cycle strobe, so no edge detector is required.

Verification
REQ-030 WIDTH=10, START with LOAD_VALUE=3, TICK every 4th cycle -> REMAINING 3,2,1,0; EXPIRED exactly one cycle, 1 cycle after the 3rd tick; BUSY high from START+1 until that tick.
REQ-031 START with LOAD_VALUE=0 -> EXPIRED on the next cycle, BUSY never high.
REQ-032 LOAD_VALUE=5, CANCEL after 2 ticks with START also high -> IDLE, REMAINING=0, no EXPIRED, BUSY low next cycle.
REQ-033 LOAD_VALUE=4, HOLD high across 3 ticks after the first -> REMAINING stays 3; after HOLD falls, 3 more ticks -> EXPIRED.
REQ-034 LOAD_VALUE=6, START with LOAD_VALUE=2 and a same-cycle TICK at REMAINING=4 -> REMAINING=2, two more ticks -> EXPIRED.
REQ-035 RST pulse at REMAINING=1 coincident with TICK -> all outputs 0, no EXPIRED pulse at any time.
